// File: rtl/rvc_asap_pkg.sv
// Shared constants and types for the rvc_asap instruction memory controller.
package rvc_asap_pkg;

    // Default instruction memory size in bytes.
    localparam int I_MEM_BYTES = 65536;

    // Supported fetch latencies: 1 = registered read, 2 = extra output register.
    localparam int I_MEM_READ_LAT_MIN = 1;
    localparam int I_MEM_READ_LAT_MAX = 2;

    // Load/run controller states.
    typedef enum logic [1:0] {
        IMEM_RUN   = 2'd0,
        IMEM_DRAIN = 2'd1,
        IMEM_LOAD  = 2'd2
    } t_imem_state;

    // True when the requested fetch latency is one the pipeline can build.
    function automatic bit imem_read_lat_ok(input int lat);
        return (lat >= I_MEM_READ_LAT_MIN) && (lat <= I_MEM_READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/rvc_asap_i_mem_array.sv
// Byte-organised instruction memory: byte-enable word write port and a
// combinational 4-byte read that wraps around the end of the array.
module rvc_asap_i_mem_array
    import rvc_asap_pkg::*;
#(
    parameter int MEM_BYTES = I_MEM_BYTES,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clock,
    input  logic [3:0]    wr_be,
    input  logic [AW-3:0] wr_word,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [7:0] mem [MEM_BYTES];

    // Byte-enable write; byte i of the word lands at word base + i.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[{wr_word, 2'(i)}] <= wr_data[8*i +: 8];
            end
        end
    end

    // Little-endian gather; the AW-bit index sum wraps modulo MEM_BYTES.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < 4; j++) begin
            rd_data[8*j +: 8] = mem[rd_addr + AW'(j)];
        end
    end

endmodule

// File: rtl/rvc_asap_i_mem_ctrl.sv
// Instruction memory controller: sync-read fetch port with 1 or 2 cycle
// latency and stall hold, plus a hardware load port guarded by a
// RUN/DRAIN/LOAD controller so fetches never interleave with loading.
//
// Load handshake: a beat transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_ready is high exactly while in LOAD, and the
// sender may hold ld_valid high across cycles without any dependency on
// ld_ready. The fetch side has no backpressure: rd_en is taken on any edge
// in RUN with rd_hold low.
//
// ADDR_W must exceed log2(MEM_BYTES); address bits above the array index
// are don't-care because the memory wraps.
module rvc_asap_i_mem_ctrl
    import rvc_asap_pkg::*;
#(
    parameter int MEM_BYTES = I_MEM_BYTES,
    parameter int READ_LAT  = 1,
    parameter int ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_hold,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_misalign,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_be,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output t_imem_state       fsm_state
);

    localparam int AW = $clog2(MEM_BYTES);
    // An unsupported latency falls back to the single-register pipeline.
    localparam bit LAT_OK = imem_read_lat_ok(READ_LAT);

    t_imem_state state;
    t_imem_state next_state;

    logic        in_run;
    logic        in_load;
    logic        accept;
    logic        beat;
    logic [3:0]  wr_be;
    logic [31:0] array_rdata;
    logic        pipe_busy;

    logic        s1_valid;
    logic        s1_mis;
    logic [31:0] s1_data;

    logic        unused_addr_bits;

    assign in_run  = (state == IMEM_RUN);
    assign in_load = (state == IMEM_LOAD);
    assign accept  = rd_en && !rd_hold && in_run;
    assign beat    = ld_valid && in_load;
    assign wr_be   = beat ? ld_be : 4'b0000;

    assign fsm_state        = state;
    assign unused_addr_bits = ^{rd_addr[ADDR_W-1:AW], ld_addr[ADDR_W-1:AW], ld_addr[1:0]};

    rvc_asap_i_mem_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clock   (clock),
        .wr_be   (wr_be),
        .wr_word (ld_addr[AW-1:2]),
        .wr_data (ld_data),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (array_rdata)
    );

    // Controller state register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IMEM_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state: leave RUN on a load request, wait for in-flight fetches,
    // return to RUN once the final beat is taken.
    always_comb begin
        next_state = state;
        unique case (state)
            IMEM_RUN:   if (ld_start)              next_state = IMEM_DRAIN;
            IMEM_DRAIN: if (!pipe_busy)            next_state = IMEM_LOAD;
            IMEM_LOAD:  if (ld_valid && ld_last)   next_state = IMEM_RUN;
            default:                               next_state = IMEM_RUN;
        endcase
    end

    // State-decoded controller outputs.
    always_comb begin
        ld_ready = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IMEM_RUN:   busy = 1'b0;
            IMEM_DRAIN: busy = 1'b1;
            IMEM_LOAD:  begin
                busy     = 1'b1;
                ld_ready = 1'b1;
            end
            default:    busy = 1'b0;
        endcase
    end

    // Completion pulse in the cycle after the final beat is written.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ld_done <= 1'b0;
        end else begin
            ld_done <= beat && ld_last;
        end
    end

    // Fetch stage 1: capture the wrapped read; odd addresses return zero data.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mis   <= 1'b0;
            s1_data  <= '0;
        end else if (!rd_hold) begin
            s1_valid <= accept;
            s1_mis   <= accept && rd_addr[0];
            s1_data  <= (accept && !rd_addr[0]) ? array_rdata : 32'h0;
        end
    end

    if (LAT_OK && (READ_LAT == 2)) begin : g_lat2
        logic        s2_valid;
        logic        s2_mis;
        logic [31:0] s2_data;

        // Output register stage, frozen by hold together with stage 1.
        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_mis   <= 1'b0;
                s2_data  <= '0;
            end else if (!rd_hold) begin
                s2_valid <= s1_valid;
                s2_mis   <= s1_mis;
                s2_data  <= s1_data;
            end
        end

        assign rd_valid    = s2_valid;
        assign rd_misalign = s2_mis;
        assign rd_data     = s2_data;
        assign pipe_busy   = s1_valid || s2_valid;
    end else begin : g_lat1
        assign rd_valid    = s1_valid;
        assign rd_misalign = s1_mis;
        assign rd_data     = s1_data;
        assign pipe_busy   = s1_valid;
    end

endmodule

// File: tb/tb_rvc_asap_i_mem_ctrl.sv
// Bench for rvc_asap_i_mem_ctrl: one instance at READ_LAT=1 and one at
// READ_LAT=2 share all inputs; a byte-array reference model and per-instance
// expected queues check every fetch, hold freeze, and load/run behaviour.
`timescale 1ns/1ps
module tb_rvc_asap_i_mem_ctrl;
    import rvc_asap_pkg::*;

    localparam int MB = 256;

    // ---------------- clock / reset / stimulus signals ----------------
    logic        clock = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        rd_hold;
    logic        ld_start;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;
    logic        ld_last;

    logic [31:0] rd_data_o   [2];
    logic        rd_valid_o  [2];
    logic        rd_mis_o    [2];
    logic        ld_ready_o  [2];
    logic        ld_done_o   [2];
    logic        busy_o      [2];
    t_imem_state fsm_o       [2];

    always #5 clock = ~clock;

    rvc_asap_i_mem_ctrl #(.MEM_BYTES(MB), .READ_LAT(1), .ADDR_W(32)) u_lat1 (
        .clock(clock), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hold(rd_hold),
        .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .rd_misalign(rd_mis_o[0]),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_be(ld_be), .ld_last(ld_last), .ld_ready(ld_ready_o[0]), .ld_done(ld_done_o[0]),
        .busy(busy_o[0]), .fsm_state(fsm_o[0])
    );

    rvc_asap_i_mem_ctrl #(.MEM_BYTES(MB), .READ_LAT(2), .ADDR_W(32)) u_lat2 (
        .clock(clock), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hold(rd_hold),
        .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .rd_misalign(rd_mis_o[1]),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_be(ld_be), .ld_last(ld_last), .ld_ready(ld_ready_o[1]), .ld_done(ld_done_o[1]),
        .busy(busy_o[1]), .fsm_state(fsm_o[1])
    );

    // ---------------- reference model and scoreboard ----------------
    logic [7:0]  ref_mem [MB];
    bit          model_run = 1'b1;
    bit          done_flag = 1'b0;
    bit          hold_q    = 1'b0;
    // Entry: {edges left before visible [34:33], misalign [32], data [31:0]}
    logic [34:0] exp_q [2][$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] prev_data  [2];
    logic        prev_valid [2];
    logic        prev_mis   [2];

    function automatic logic [31:0] ref_fetch(input logic [31:0] a);
        logic [31:0] r;
        int unsigned base;
        base = a % MB;
        for (int j = 0; j < 4; j++) begin
            r[8*j +: 8] = ref_mem[(base + j) % MB];
        end
        return r;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (lat%0d) at %0t: got %h, expected %h", name, d + 1, $time, act, exp);
        end
    endtask

    // Model update at each active edge, using pre-edge input values.
    always @(posedge clock) begin
        logic [34:0] e;
        int unsigned base;
        hold_q = rd_hold;
        if (rst) begin
            model_run = 1'b1;
            done_flag = 1'b0;
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            done_flag = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (!rd_hold) begin
                    for (int i = 0; i < exp_q[d].size(); i++) begin
                        e = exp_q[d][i];
                        if (e[34:33] != 2'd0) begin
                            e[34:33] = e[34:33] - 2'd1;
                            exp_q[d][i] = e;
                        end
                    end
                end
                if (model_run && rd_en && !rd_hold) begin
                    e = {2'(d), rd_addr[0], rd_addr[0] ? 32'h0 : ref_fetch(rd_addr)};
                    exp_q[d].push_back(e);
                end
            end
            if (!model_run && ld_valid && ld_ready_o[0] && ld_ready_o[1]) begin
                base = ld_addr % MB;
                base = base - (base % 4);
                for (int i = 0; i < 4; i++) begin
                    if (ld_be[i]) ref_mem[base + i] = ld_data[8*i +: 8];
                end
                if (ld_last) begin
                    model_run = 1'b1;
                    done_flag = 1'b1;
                end
            end else if (model_run && ld_start) begin
                model_run = 1'b0;
            end
        end
    end

    // Monitor: compare outputs mid-cycle against the expected queues.
    always @(negedge clock) begin
        logic [34:0] e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("reset rd_valid", d, 32'(rd_valid_o[d]), 32'd0);
                chk("reset rd_misalign", d, 32'(rd_mis_o[d]), 32'd0);
                chk("reset rd_data", d, rd_data_o[d], 32'd0);
                chk("reset ld_ready", d, 32'(ld_ready_o[d]), 32'd0);
                chk("reset ld_done", d, 32'(ld_done_o[d]), 32'd0);
                chk("reset busy", d, 32'(busy_o[d]), 32'd0);
            end else begin
                if (hold_q) begin
                    chk("hold rd_valid frozen", d, 32'(rd_valid_o[d]), 32'(prev_valid[d]));
                    chk("hold rd_misalign frozen", d, 32'(rd_mis_o[d]), 32'(prev_mis[d]));
                    chk("hold rd_data frozen", d, rd_data_o[d], prev_data[d]);
                end else if (exp_q[d].size() > 0 && exp_q[d][0][34:33] == 2'd0) begin
                    e = exp_q[d].pop_front();
                    chk("fetch rd_valid", d, 32'(rd_valid_o[d]), 32'd1);
                    chk("fetch rd_misalign", d, 32'(rd_mis_o[d]), 32'(e[32]));
                    chk("fetch rd_data", d, rd_data_o[d], e[31:0]);
                end else begin
                    chk("no fetch due rd_valid", d, 32'(rd_valid_o[d]), 32'd0);
                end
                chk("busy", d, 32'(busy_o[d]), 32'(!model_run));
                chk("fsm in run", d, 32'(fsm_o[d] == IMEM_RUN), 32'(model_run));
                chk("ld_done", d, 32'(ld_done_o[d]), 32'(done_flag));
                if (ld_ready_o[d]) begin
                    chk("ld_ready only when drained", d, 32'(exp_q[d].size()), 32'd0);
                    chk("ld_ready only outside run", d, 32'(model_run), 32'd0);
                end
            end
            prev_data[d]  = rd_data_o[d];
            prev_valid[d] = rd_valid_o[d];
            prev_mis[d]   = rd_mis_o[d];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en    = 1'b0;
        rd_hold  = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_be    = 4'h0;
    endtask

    task automatic fetch(input logic [31:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
    endtask

    // Request load mode and wait (bounded) for both instances to be ready.
    task automatic enter_load();
        ld_valid = 1'b0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int k = 0; k < 20 && !(ld_ready_o[0] && ld_ready_o[1]); k++) step();
        chk("load entry ready", 0, 32'(ld_ready_o[0]), 32'd1);
        chk("load entry ready", 1, 32'(ld_ready_o[1]), 32'd1);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] be, input bit last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = dat;
        ld_be    = be;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rd_addr = '0;
        ld_addr = '0;
        ld_data = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Fill the whole array with random words so every fetch is defined.
        enter_load();
        for (int w = 0; w < MB / 4; w++) send_beat(32'(w * 4), $urandom, 4'hf, (w == MB / 4 - 1));
        step();

        // Basic load then aligned, half-aligned and odd fetches.
        enter_load();
        send_beat(32'd0, 32'h0000_0013, 4'hf, 1'b0);
        send_beat(32'd4, 32'hDEAD_BEEF, 4'hf, 1'b1);
        fetch(32'd4);
        fetch(32'd2);
        fetch(32'd3);
        repeat (4) step();

        // Wrap-around fetch across the top of the array.
        enter_load();
        send_beat(32'(MB - 4), 32'h4433_2211, 4'hf, 1'b0);
        send_beat(32'd0, 32'h8877_6655, 4'hf, 1'b1);
        fetch(32'(MB - 2));
        repeat (4) step();

        // Back-to-back fetches with a 3-cycle hold in the middle.
        rd_en = 1'b1; rd_addr = 32'd0; step();
        rd_addr = 32'd4; step();
        rd_hold = 1'b1; rd_addr = 32'd100;
        repeat (3) step();
        rd_hold = 1'b0; rd_addr = 32'd8; step();
        rd_en = 1'b0;
        repeat (4) step();

        // Load request with fetches in flight; rd_en kept high through DRAIN/LOAD.
        rd_en = 1'b1; rd_addr = 32'd8; step();
        rd_addr = 32'd12;
        enter_load();
        rd_addr = 32'd16;
        repeat (2) step();
        rd_en = 1'b0;
        send_beat(32'd40, 32'hCAFE_F00D, 4'hf, 1'b1);
        fetch(32'd40);
        repeat (3) step();

        // Load beats outside LOAD must not write.
        ld_valid = 1'b1; ld_addr = 32'd20; ld_data = 32'h1234_5678; ld_be = 4'hf; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        fetch(32'd20);
        repeat (3) step();

        // Partial byte enables, then reset in the middle of a later beat.
        enter_load();
        send_beat(32'd64, 32'h1122_3344, 4'hf, 1'b1);
        step();
        enter_load();
        send_beat(32'd64, 32'hAABB_CCDD, 4'b0101, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'd64; ld_data = 32'h0; ld_be = 4'hf; ld_last = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld_valid = 1'b0;
        step();
        fetch(32'd64);
        repeat (3) step();

        // Randomised traffic: fetches, holds, stray beats and occasional loads.
        for (int c = 0; c < 400; c++) begin
            rd_en   = ($urandom_range(0, 3) != 0);
            rd_addr = $urandom;
            if ($urandom_range(0, 3) != 0) rd_addr[0] = 1'b0;
            rd_hold = ($urandom_range(0, 5) == 0);
            ld_valid = ($urandom_range(0, 15) == 0);
            ld_addr  = $urandom;
            ld_data  = $urandom;
            ld_be    = 4'($urandom_range(0, 15));
            ld_last  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) begin
                rd_hold = 1'b0;
                enter_load();
                for (int b = $urandom_range(1, 4); b > 0; b--) begin
                    send_beat($urandom, $urandom, 4'($urandom_range(0, 15)), (b == 1));
                end
            end else begin
                step();
            end
        end

        idle_inputs();
        repeat (6) step();
        chk("scoreboard drained", 0, 32'(exp_q[0].size()), 32'd0);
        chk("scoreboard drained", 1, 32'(exp_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
